// File: rtl/cache_param_pkg.sv
// rtl/cache_param_pkg.sv - shared types and defaults for the far-memory responder
package cache_param_pkg;

   localparam int FM_ADRS_WIDTH_DEFAULT = 10;
   localparam int CL_WIDTH              = 64;
   localparam int FM_ADDR_BITS          = 16;
   localparam int TQ_ID_WIDTH           = 4;

   typedef enum logic [1:0] {
      FM_NOP_OP      = 2'd0,
      FILL_REQ       = 2'd1,
      DIRTY_EVICT_OP = 2'd2
   } t_fm_opcode;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WAIT = 2'd2,
      RSP  = 2'd3
   } t_fm_state;

   typedef struct packed {
      logic                    valid;
      t_fm_opcode              opcode;
      logic [FM_ADDR_BITS-1:0] address;
      logic [TQ_ID_WIDTH-1:0]  tq_id;
      logic [CL_WIDTH-1:0]     data;
   } t_fm_req;

   typedef struct packed {
      logic                    valid;
      logic [FM_ADDR_BITS-1:0] address;
      logic [TQ_ID_WIDTH-1:0]  tq_id;
      logic [CL_WIDTH-1:0]     data;
   } t_fm_rd_rsp;

endpackage

// File: rtl/fm_req_fifo.sv
// rtl/fm_req_fifo.sv - request queue with extra-MSB pointers, push on full allowed with same-cycle pop
module fm_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_data    = r_mem[r_rptr[AW-1:0]];
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Head is read combinationally before the edge, so overwriting it on full push+pop is safe.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/cache_fm_responder.sv
// rtl/cache_fm_responder.sv - far-memory model answering FILLs after a fixed latency and absorbing evicts
module cache_fm_responder
   import cache_param_pkg::*;
#(
   parameter int FM_LATENCY     = 8,
   parameter int REQ_FIFO_DEPTH = 4,
   parameter int FM_ADRS_WIDTH  = FM_ADRS_WIDTH_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  t_fm_req    cache2fm_req_q3,
   output t_fm_rd_rsp fm2cache_rd_rsp,
   output logic       fm_busy,
   output logic       fm_overflow_err
);

   localparam int LINES = 1 << FM_ADRS_WIDTH;
   localparam int CNT_W = $clog2(FM_LATENCY) + 1;
   localparam int REQ_W = $bits(t_fm_req);

   t_fm_state               r_state;
   t_fm_state               w_next;
   t_fm_req                 w_head;
   t_fm_req                 r_req;
   logic [REQ_W-1:0]        w_head_bits;
   logic                    w_pop;
   logic                    w_empty;
   logic                    w_full;
   logic                    w_drop;
   logic                    w_is_fill;
   logic                    w_is_evict;
   logic                    r_ovf;
   logic [CNT_W-1:0]        r_cnt;
   logic [CL_WIDTH-1:0]     r_rdata;
   logic [LINES-1:0]        r_written;
   logic [CL_WIDTH-1:0]     r_mem [LINES];
   logic [FM_ADRS_WIDTH-1:0] w_idx;

   fm_req_fifo #(
      .DEPTH (REQ_FIFO_DEPTH),
      .WIDTH (REQ_W)
   ) u_req_fifo (
      .clk     (clk),
      .i_rst_n (rst),
      .i_push  (cache2fm_req_q3.valid),
      .i_data  (cache2fm_req_q3),
      .i_pop   (w_pop),
      .o_data  (w_head_bits),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign w_head          = w_head_bits;
   assign w_idx           = r_req.address[FM_ADRS_WIDTH-1:0];
   assign w_is_fill       = r_req.valid && (r_req.opcode == FILL_REQ);
   assign w_is_evict      = r_req.valid && (r_req.opcode == DIRTY_EVICT_OP);
   assign w_drop          = cache2fm_req_q3.valid && w_full && !w_pop;
   assign fm_overflow_err = r_ovf || w_drop;
   assign fm_busy         = !w_empty || (r_state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // Leaving WAIT when the counter is about to hit zero lands RSP FM_LATENCY+1 cycles after the pop.
   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = EXEC;
            end
         end
         EXEC:    w_next = w_is_fill ? WAIT : IDLE;
         WAIT:    if (r_cnt <= CNT_W'(1)) w_next = RSP;
         RSP:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_req     <= '0;
         r_cnt     <= '0;
         r_rdata   <= '0;
         r_written <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_pop) r_req <= w_head;
         if (r_state == EXEC && w_is_fill) begin
            r_rdata <= r_written[w_idx] ? r_mem[w_idx] : '0;
            r_cnt   <= CNT_W'(FM_LATENCY - 1);
         end else if (r_state == WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (r_state == EXEC && w_is_evict) r_written[w_idx] <= 1'b1;
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == EXEC && w_is_evict) r_mem[w_idx] <= r_req.data;
   end

   always_comb begin
      fm2cache_rd_rsp = '0;
      if (r_state == RSP) begin
         fm2cache_rd_rsp.valid   = 1'b1;
         fm2cache_rd_rsp.address = r_req.address;
         fm2cache_rd_rsp.tq_id   = r_req.tq_id;
         fm2cache_rd_rsp.data    = r_rdata;
      end
   end

endmodule

// File: tb/tb_cache_fm_responder.sv
// tb/tb_cache_fm_responder.sv - scoreboard bench for cache_fm_responder
module tb_cache_fm_responder;
   import cache_param_pkg::*;

   typedef struct {
      logic [15:0] addr;
      logic [3:0]  tq;
      logic [63:0] data;
      int          cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   t_fm_req    req;
   t_fm_rd_rsp rsp;
   logic       busy;
   logic       ovf;
   int         cyc = 0;
   int         last_cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   exp_t       sb[$];
   exp_t       mon_e;

   localparam logic [63:0] D_A5 = 64'hA5A5_A5A5_A5A5_A5A5;

   cache_fm_responder #(
      .FM_LATENCY     (8),
      .REQ_FIFO_DEPTH (4),
      .FM_ADRS_WIDTH  (10)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cache2fm_req_q3 (req),
      .fm2cache_rd_rsp (rsp),
      .fm_busy         (busy),
      .fm_overflow_err (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (rsp.valid) begin
            if (sb.size() == 0) begin
               check("unexpected_rsp", 64'(rsp.tq_id) | 64'h100, 64'h0);
            end else begin
               mon_e = sb.pop_front();
               check("rsp_addr", 64'(rsp.address), 64'(mon_e.addr));
               check("rsp_tq_id", 64'(rsp.tq_id), 64'(mon_e.tq));
               check("rsp_data", rsp.data, mon_e.data);
               if (mon_e.cyc >= 0) check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
         end else begin
            check("idle_fields_zero",
                  64'((rsp.address != '0) || (rsp.tq_id != '0) || (rsp.data != '0)), 64'h0);
         end
      end
   end

   task automatic push(input logic [1:0] op, input logic [15:0] addr,
                       input logic [3:0] tq, input logic [63:0] data);
      @(posedge clk);
      #1;
      req.valid   = 1'b1;
      req.opcode  = t_fm_opcode'(op);
      req.address = addr;
      req.tq_id   = tq;
      req.data    = data;
      last_cyc    = cyc;
   endtask

   task automatic fill(input logic [15:0] addr, input logic [3:0] tq,
                       input logic [63:0] exp_data, input int ofs);
      exp_t e;
      push(2'd1, addr, tq, 64'h0);
      e.addr = addr;
      e.tq   = tq;
      e.data = exp_data;
      e.cyc  = (ofs < 0) ? -1 : last_cyc + ofs;
      sb.push_back(e);
   endtask

   task automatic nop(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         req = '0;
      end
   endtask

   task automatic wait_neg_cyc(input int target);
      do @(negedge clk); while (cyc < target);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while ((busy || sb.size() != 0) && k < 400);
      check("drain", 64'(busy || sb.size() != 0), 64'h0);
   endtask

   logic [15:0] s4_addr [6];
   logic [63:0] s4_data [6];
   int          c;
   int          k;

   initial begin
      s4_addr = '{16'h12, 16'h5, 16'h40, 16'h12, 16'h7, 16'h9};
      s4_data = '{D_A5, 64'h1, 64'h0, D_A5, 64'h0, 64'h0};
      rst = 1'b0;
      req = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'h0);
      check("reset_ovf", 64'(ovf), 64'h0);
      check("reset_rsp", 64'(rsp), 64'h0);
      rst = 1'b1;

      // Evict then fill the same line; fill pop lands 2 cycles after its push.
      push(2'd2, 16'h12, 4'd0, D_A5);
      fill(16'h12, 4'd3, D_A5, 11);
      nop(1);
      wait_idle();

      fill(16'h40, 4'd2, 64'h0, 10);
      c = last_cyc;
      nop(1);
      wait_neg_cyc(c + 9);
      check("unwritten_pre", 64'(rsp.valid), 64'h0);
      wait_neg_cyc(c + 10);
      check("unwritten_valid", 64'(rsp.valid), 64'h1);
      wait_neg_cyc(c + 11);
      check("unwritten_post", 64'(rsp.valid), 64'h0);
      wait_idle();

      // Invalid opcode must not disturb the line.
      push(2'd2, 16'h5, 4'd0, 64'h1);
      fill(16'h5, 4'd5, 64'h1, 11);
      push(2'd3, 16'h5, 4'd0, 64'hDEAD);
      fill(16'h5, 4'd6, 64'h1, -1);
      nop(1);
      wait_idle();

      for (int i = 0; i < 6; i++) begin
         if (i < 5) fill(s4_addr[i], 4'(i + 1), s4_data[i], -1);
         else       push(2'd1, s4_addr[i], 4'(i + 1), 64'h0);
         @(negedge clk);
         if (i == 4) check("ovf_before_6th", 64'(ovf), 64'h0);
         if (i == 5) check("ovf_on_6th", 64'(ovf), 64'h1);
      end
      nop(1);
      wait_idle();
      check("ovf_sticky", 64'(ovf), 64'h1);

      push(2'd1, 16'h12, 4'd7, 64'h0);
      nop(1);
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("rst_async_busy", 64'(busy), 64'h0);
      check("rst_async_ovf", 64'(ovf), 64'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_busy", 64'(busy), 64'h0);
      check("post_rst_ovf", 64'(ovf), 64'h0);

      // Written bits were cleared by reset, so 0x12 now reads zero.
      fill(16'h12, 4'd8, 64'h0, 10);
      push(2'd2, 16'h20, 4'd0, 64'h1234);
      fill(16'h20, 4'd9, 64'h1234, -1);
      fill(16'h3, 4'd10, 64'h0, -1);
      fill(16'h20, 4'd11, 64'h1234, -1);
      nop(1);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!rsp.valid && k < 50);
      check("first_rsp_seen", 64'(rsp.valid), 64'h1);
      fill(16'h12, 4'd12, 64'h0, -1);
      @(negedge clk);
      check("full_push_pop_ovf", 64'(ovf), 64'h0);
      nop(1);
      wait_idle();
      check("final_ovf", 64'(ovf), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
